// File: rtl/mda_text_engine.sv
// MDA text-mode display engine: counters -> text RAM -> font ROM -> attribute decode -> sync/video pins.
// Latency: 4 clocks from raw h/v counters to MDA_* outputs; frame_start is raw (undelayed).
// Backpressure: none; free-running pixel pipeline, one address per clock to each read port.
module mda_text_engine #(
   parameter int H_ACTIVE     = 720,
   parameter int H_SYNC_START = 731,
   parameter int H_SYNC_END   = 866,
   parameter int H_TOTAL      = 884,
   parameter int V_ACTIVE     = 350,
   parameter int V_SYNC_START = 349,
   parameter int V_SYNC_END   = 365,
   parameter int V_TOTAL      = 369,
   parameter int CELL_W       = 9,
   parameter int CELL_H       = 14,
   parameter int UL_LINE      = 12,
   parameter int COLS         = 80,
   parameter int ROWS         = 25,
   parameter int BLINK_FRAMES = 16,
   localparam int AW          = $clog2(COLS*ROWS),
   localparam int RW          = $clog2(ROWS),
   localparam int CW          = $clog2(COLS)
) (
   input  logic          clock,
   input  logic          rst_n,
   output logic [AW-1:0] text_addr,
   input  logic [15:0]   text_data,
   output logic [11:0]   font_addr,
   input  logic [7:0]    font_data,
   input  logic          cursor_en,
   input  logic [RW-1:0] cursor_row,
   input  logic [CW-1:0] cursor_col,
   input  logic [3:0]    cursor_start,
   input  logic [3:0]    cursor_end,
   output logic          MDA_HSYNC,
   output logic          MDA_VSYNC,
   output logic          MDA_DATA,
   output logic          MDA_INTENSITY,
   output logic          frame_start
);

   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int BW = $clog2(BLINK_FRAMES + 1);

   // Geometry must tile the active area exactly; cell fields are sized for 4-bit px/scanline.
   if (H_ACTIVE != COLS*CELL_W || V_ACTIVE != ROWS*CELL_H) begin : g_bad_geometry
      $error("mda_text_engine: active area does not match COLS*CELL_W x ROWS*CELL_H");
   end
   if (CELL_W < 8 || CELL_W > 16 || CELL_H > 16 || ROWS < 2 || COLS < 2 || BLINK_FRAMES < 2) begin : g_bad_limits
      $error("mda_text_engine: cell size, grid or blink period out of range");
   end

   // Stage 0 state
   logic          run_q;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [3:0]    px_q, px_d;
   logic [CW-1:0] col_q, col_d;
   logic [3:0]    sl_q, sl_d;
   logic [RW-1:0] row_q, row_d;
   logic          act0, hs0, vs0, cur0;
   logic [AW-1:0] text_addr_d;

   // Stage 1..3 sideband and data
   logic [3:0] px1_q, sl1_q, px2_q, sl2_q, sl3_q;
   logic       act1_q, hs1_q, vs1_q, cur1_q;
   logic       act2_q, hs2_q, vs2_q, cur2_q, lg2_q;
   logic       act3_q, hs3_q, vs3_q, cur3_q, pix3_q;
   logic [7:0] attr2_q, attr3_q;
   logic       pix_d;

   // Blink state and stage 4 decode
   logic [BW-1:0] char_cnt_q, cur_cnt_q;
   logic          char_on_q, cur_on_q;
   logic [2:0]    fg, bg;
   logic          blank, data_d, inten_d;

   // Raw counters; run_q holds them at 0,0 for the first clock after reset so frame_start
   // appears exactly one clock after release.
   always_comb begin
      h_d   = h_q;
      v_d   = v_q;
      px_d  = px_q;
      col_d = col_q;
      sl_d  = sl_q;
      row_d = row_q;
      if (run_q) begin
         if (h_q == HW'(H_TOTAL-1)) begin
            h_d   = '0;
            px_d  = '0;
            col_d = '0;
            if (v_q == VW'(V_TOTAL-1)) begin
               v_d   = '0;
               sl_d  = '0;
               row_d = '0;
            end else begin
               v_d = v_q + 1'b1;
               if (v_q < VW'(V_ACTIVE)) begin
                  if (sl_q == 4'(CELL_H-1)) begin
                     sl_d = '0;
                     if (row_q != RW'(ROWS-1)) row_d = row_q + 1'b1;
                  end else begin
                     sl_d = sl_q + 1'b1;
                  end
               end
            end
         end else begin
            h_d = h_q + 1'b1;
            if (h_q < HW'(H_ACTIVE)) begin
               if (px_q == 4'(CELL_W-1)) begin
                  px_d = '0;
                  if (col_q != CW'(COLS-1)) col_d = col_q + 1'b1;
               end else begin
                  px_d = px_q + 1'b1;
               end
            end
         end
      end
   end

   // Stage 0 region/sync/cursor decode of the raw position
   always_comb begin
      act0 = run_q && (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
      hs0  = run_q && (h_q >= HW'(H_SYNC_START)) && (h_q < HW'(H_SYNC_END));
      vs0  = run_q && (v_q >= VW'(V_SYNC_START)) && (v_q < VW'(V_SYNC_END));
      cur0 = cursor_en && (row_q == cursor_row) && (col_q == cursor_col) &&
             (sl_q >= cursor_start) && (sl_q <= cursor_end);
      text_addr_d = AW'(row_q) * AW'(COLS) + AW'(col_q);
      frame_start = run_q && (h_q == '0) && (v_q == '0);
   end

   // Counter and run-flag registers
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         h_q   <= '0;
         v_q   <= '0;
         px_q  <= '0;
         col_q <= '0;
         sl_q  <= '0;
         row_q <= '0;
      end else begin
         run_q <= 1'b1;
         h_q   <= h_d;
         v_q   <= v_d;
         px_q  <= px_d;
         col_q <= col_d;
         sl_q  <= sl_d;
         row_q <= row_d;
      end
   end

   // Stage 3 pixel select; column 9 replicates bit 0 only for the 0xC0..0xDF line-graphics range
   always_comb begin
      if (px2_q < 4'd8) pix_d = font_data[~px2_q[2:0]];
      else              pix_d = lg2_q & font_data[0];
   end

   // Stage 4 attribute decode; cursor overrides everything, blanking overrides the cursor
   always_comb begin
      fg    = attr3_q[2:0];
      bg    = attr3_q[6:4];
      blank = attr3_q[7] & ~char_on_q;
      if ((attr3_q & 8'h77) == 8'h00)       data_d = 1'b0;
      else if (fg == 3'd0 && bg == 3'd7)    data_d = blank ? 1'b1 : ~pix3_q;
      else                                  data_d = ~blank & (pix3_q | (fg == 3'd1 && sl3_q == 4'(UL_LINE)));
      inten_d = attr3_q[3] & data_d;
      if (cur3_q && cur_on_q) begin
         data_d  = 1'b1;
         inten_d = 1'b1;
      end
      if (!act3_q) begin
         data_d  = 1'b0;
         inten_d = 1'b0;
      end
   end

   // Pixel pipeline: address to text RAM, then font ROM, then pixel, then registered pins
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         text_addr <= '0;
         px1_q <= '0; sl1_q <= '0; act1_q <= 1'b0; hs1_q <= 1'b0; vs1_q <= 1'b0; cur1_q <= 1'b0;
         font_addr <= '0;
         attr2_q <= '0; lg2_q <= 1'b0;
         px2_q <= '0; sl2_q <= '0; act2_q <= 1'b0; hs2_q <= 1'b0; vs2_q <= 1'b0; cur2_q <= 1'b0;
         pix3_q <= 1'b0; attr3_q <= '0;
         sl3_q <= '0; act3_q <= 1'b0; hs3_q <= 1'b0; vs3_q <= 1'b0; cur3_q <= 1'b0;
         MDA_HSYNC     <= 1'b0;
         MDA_VSYNC     <= 1'b1;
         MDA_DATA      <= 1'b0;
         MDA_INTENSITY <= 1'b0;
      end else begin
         text_addr <= text_addr_d;
         px1_q <= px_q; sl1_q <= sl_q; act1_q <= act0; hs1_q <= hs0; vs1_q <= vs0; cur1_q <= cur0;
         font_addr <= {text_data[7:0], sl1_q};
         attr2_q   <= text_data[15:8];
         lg2_q     <= (text_data[7:5] == 3'b110);
         px2_q <= px1_q; sl2_q <= sl1_q; act2_q <= act1_q; hs2_q <= hs1_q; vs2_q <= vs1_q; cur2_q <= cur1_q;
         pix3_q  <= pix_d;
         attr3_q <= attr2_q;
         sl3_q <= sl2_q; act3_q <= act2_q; hs3_q <= hs2_q; vs3_q <= vs2_q; cur3_q <= cur2_q;
         MDA_HSYNC     <= hs3_q;
         MDA_VSYNC     <= ~vs3_q;
         MDA_DATA      <= data_d;
         MDA_INTENSITY <= inten_d;
      end
   end

   // Blink phases: a counter of frame starts since the last toggle; the first frame after
   // reset counts as frame 0 of an "on" half period.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         char_cnt_q <= '0;
         cur_cnt_q  <= '0;
         char_on_q  <= 1'b1;
         cur_on_q   <= 1'b1;
      end else if (frame_start) begin
         if (char_cnt_q == BW'(BLINK_FRAMES)) begin
            char_cnt_q <= BW'(1);
            char_on_q  <= ~char_on_q;
         end else begin
            char_cnt_q <= char_cnt_q + 1'b1;
         end
         if (cur_cnt_q == BW'(BLINK_FRAMES/2)) begin
            cur_cnt_q <= BW'(1);
            cur_on_q  <= ~cur_on_q;
         end else begin
            cur_cnt_q <= cur_cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mda_text_engine.sv
// Bench for mda_text_engine on a reduced 6x4-cell screen so several frames fit in a short run.
// Expected pixels are queued up front; a monitor keyed on frame_start pops and compares them.
module tb_mda_text_engine;
   localparam int HA = 54, HSS = 58, HSE = 70, HT = 76;
   localparam int VA = 56, VSS = 54, VSE = 59, VT = 62;
   localparam int NC = 6, NR = 4, BF = 2;
   localparam int FRAME = HT * VT;
   localparam int LAT = 4;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  text_addr;
   logic [15:0] text_data;
   logic [11:0] font_addr;
   logic [7:0]  font_data;
   logic        cursor_en;
   logic [1:0]  cursor_row;
   logic [2:0]  cursor_col;
   logic [3:0]  cursor_start, cursor_end;
   logic        MDA_HSYNC, MDA_VSYNC, MDA_DATA, MDA_INTENSITY, frame_start;

   mda_text_engine #(
      .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
      .CELL_W(9), .CELL_H(14), .UL_LINE(12), .COLS(NC), .ROWS(NR), .BLINK_FRAMES(BF)
   ) dut (
      .clock(clock), .rst_n(rst_n),
      .text_addr(text_addr), .text_data(text_data),
      .font_addr(font_addr), .font_data(font_data),
      .cursor_en(cursor_en), .cursor_row(cursor_row), .cursor_col(cursor_col),
      .cursor_start(cursor_start), .cursor_end(cursor_end),
      .MDA_HSYNC(MDA_HSYNC), .MDA_VSYNC(MDA_VSYNC), .MDA_DATA(MDA_DATA),
      .MDA_INTENSITY(MDA_INTENSITY), .frame_start(frame_start)
   );

   always #5 clock = ~clock;

   // Memories answer in the cycle after the engine registers an address.
   logic [15:0] text_mem [NC*NR];

   function automatic logic [7:0] font_fn(input logic [11:0] a);
      case (a[11:4])
         8'h41:   return (a[3:0] < 4'd7) ? 8'hFF : 8'h01;
         8'hC4:   return 8'h01;
         default: return 8'h00;
      endcase
   endfunction

   always_comb text_data = (int'(text_addr) < NC*NR) ? text_mem[text_addr] : 16'h0000;
   always_comb font_data = font_fn(font_addr);

   typedef struct {
      int    k;
      logic  d;
      logic  i;
      string name;
   } exp_t;

   exp_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected output of raw pixel (v,h) of frame f, seen LAT clocks after it is counted.
   task automatic expect_px(input int f, input int v, input int h, input logic d, input logic i,
                            input string name);
      sb.push_back('{f*FRAME + v*HT + h + LAT, d, i, name});
   endtask

   // Monitor: clock index k counts from the first frame_start; compares queued pixels and
   // measures sync pulse positions/widths over the first two frames.
   initial begin : monitor
      int   kabs, last_fs, hs_rise, vs_fall;
      logic hs_prev, vs_prev;
      kabs = -1; last_fs = 0; hs_rise = -1; vs_fall = -1;
      hs_prev = 1'b0; vs_prev = 1'b1;
      forever begin
         @(negedge clock);
         if (!mon_en) continue;
         if (kabs >= 0) kabs++;
         if (frame_start) begin
            if (kabs < 0) kabs = 0;
            else chk("fs_period", kabs - last_fs, FRAME);
            last_fs = kabs;
         end
         if (kabs >= 0) begin
            for (int j = sb.size() - 1; j >= 0; j--) begin
               if (sb[j].k == kabs) begin
                  chk({sb[j].name, "_data"}, MDA_DATA, sb[j].d);
                  chk({sb[j].name, "_int"}, MDA_INTENSITY, sb[j].i);
                  sb.delete(j);
               end
            end
            if (kabs < 2*FRAME) begin
               if (MDA_HSYNC && !hs_prev) begin
                  chk("hs_phase", (kabs - LAT) % HT, HSS);
                  if (hs_rise >= 0) chk("hs_period", kabs - hs_rise, HT);
                  hs_rise = kabs;
               end
               if (!MDA_HSYNC && hs_prev) chk("hs_width", kabs - hs_rise, HSE - HSS);
               if (!MDA_VSYNC && vs_prev) begin
                  chk("vs_phase", kabs - last_fs, VSS*HT + LAT);
                  vs_fall = kabs;
               end
               if (MDA_VSYNC && !vs_prev) chk("vs_width", kabs - vs_fall, (VSE - VSS)*HT);
            end
            hs_prev = MDA_HSYNC;
            vs_prev = MDA_VSYNC;
         end
      end
   end

   initial begin : stimulus
      int seen;
      for (int a = 0; a < NC*NR; a++) text_mem[a] = 16'h0720;
      text_mem[0] = 16'h0741;   // 'A', normal
      text_mem[1] = 16'h07C4;   // line-graphics char
      text_mem[2] = 16'h7020;   // reverse
      text_mem[3] = 16'h0120;   // underline
      text_mem[4] = 16'h0041;   // non-display
      text_mem[5] = 16'h8F41;   // blinking, bright
      text_mem[6] = 16'hF041;   // blinking reverse (row 1, col 0)
      cursor_en = 1'b1; cursor_row = 2'd3; cursor_col = 3'd5;
      cursor_start = 4'd12; cursor_end = 4'd13;

      sb.push_back('{LAT - 1, 1'b0, 1'b0, "before_first"});
      expect_px(0, 0, 0, 1, 0, "a_px0");          expect_px(0, 0, 7, 1, 0, "a_px7");
      expect_px(0, 0, 8, 0, 0, "a_px8");          expect_px(0, 7, 0, 0, 0, "a_sl7_px0");
      expect_px(0, 7, 7, 1, 0, "a_sl7_px7");      expect_px(0, 7, 8, 0, 0, "nonlg_px8");
      expect_px(0, 0, 9, 0, 0, "lg_px0");         expect_px(0, 0, 16, 1, 0, "lg_px7");
      expect_px(0, 0, 17, 1, 0, "lg_px8");
      expect_px(0, 0, 18, 1, 0, "rev_px0");       expect_px(0, 0, 26, 1, 0, "rev_px8");
      expect_px(0, 11, 30, 0, 0, "ul_sl11");      expect_px(0, 12, 30, 1, 0, "ul_sl12");
      expect_px(0, 12, 35, 1, 0, "ul_px8");
      expect_px(0, 0, 36, 0, 0, "nd_px0");        expect_px(0, 0, 43, 0, 0, "nd_px7");
      expect_px(0, 0, 45, 1, 1, "blk_on_px0");    expect_px(0, 0, 53, 0, 0, "blk_on_px8");
      expect_px(0, 14, 0, 0, 0, "revblk_on_px0"); expect_px(0, 14, 8, 1, 0, "revblk_on_px8");
      expect_px(0, 53, 45, 0, 0, "cur_sl11");     expect_px(0, 54, 45, 1, 1, "cur_sl12");
      expect_px(0, 55, 53, 1, 1, "cur_sl13_px8"); expect_px(0, 54, 44, 0, 0, "cur_left");
      expect_px(0, 0, 54, 0, 0, "hblank");        expect_px(0, 56, 0, 0, 0, "vblank");
      expect_px(1, 54, 45, 0, 0, "cur_off_f1");   expect_px(1, 0, 45, 1, 1, "blk_on_f1");
      expect_px(2, 0, 45, 0, 0, "blk_off_f2");    expect_px(2, 0, 0, 1, 0, "a_f2");
      expect_px(2, 14, 0, 1, 0, "revblk_off_f2"); expect_px(2, 54, 45, 1, 1, "cur_on_f2");
      expect_px(3, 0, 45, 0, 0, "blk_off_f3");    expect_px(3, 54, 45, 0, 0, "cur_off_f3");
      expect_px(4, 0, 45, 1, 1, "blk_on_f4");

      repeat (3) @(negedge clock);
      chk("rst_hsync", MDA_HSYNC, 1'b0);
      chk("rst_vsync", MDA_VSYNC, 1'b1);
      chk("rst_data", MDA_DATA, 1'b0);
      chk("rst_int", MDA_INTENSITY, 1'b0);
      chk("rst_fs", frame_start, 1'b0);
      chk("rst_text_addr", text_addr, 5'd0);
      chk("rst_font_addr", font_addr, 12'd0);

      #1 rst_n = 1'b1;
      @(negedge clock);
      chk("fs_after_release", frame_start, 1'b1);

      // Run to the start of frame 4
      seen = 1;
      for (int c = 0; c < 6*FRAME && seen < 5; c++) begin
         @(negedge clock);
         if (frame_start) seen++;
      end
      chk("frames_seen", seen, 5);

      // Stop inside the cursor cell of frame 4 (cursor on, VSYNC low) and reset mid-line
      repeat (54*HT + 45 + LAT) @(negedge clock);
      mon_en = 1'b0;
      chk("pre_rst_data", MDA_DATA, 1'b1);
      chk("pre_rst_int", MDA_INTENSITY, 1'b1);
      chk("pre_rst_vsync", MDA_VSYNC, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_hsync", MDA_HSYNC, 1'b0);
      chk("mid_rst_vsync", MDA_VSYNC, 1'b1);
      chk("mid_rst_data", MDA_DATA, 1'b0);
      chk("mid_rst_int", MDA_INTENSITY, 1'b0);
      chk("mid_rst_fs", frame_start, 1'b0);
      chk("mid_rst_text_addr", text_addr, 5'd0);
      chk("mid_rst_font_addr", font_addr, 12'd0);
      chk("sb_unchecked", sb.size(), 0);

      repeat (2) @(negedge clock);
      #1 rst_n = 1'b1;
      @(negedge clock);
      chk("fs_after_rerelease", frame_start, 1'b1);
      chk("data_after_rerelease", MDA_DATA, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/mda_text_engine.md
# mda_text_engine

Parametrised MDA text-mode display engine: the successor to the fixed-timing MDA pattern core. Generates MDA-compatible HSYNC/VSYNC/DATA/INTENSITY from a character/attribute buffer and a font ROM, both external synchronous-read memories. Adds programmable timing and cell geometry, MDA attribute decode (intensity, underline, reverse, blink, non-display), 9th-column line-graphics replication and a blinking hardware cursor. Sits between the pixel PLL/top level and the text RAM written by the host side.

## Interface

- H_ACTIVE, 720: active pixels per line
- H_SYNC_START, 731: hcount at which HSYNC asserts
- H_SYNC_END, 866: hcount at which HSYNC deasserts
- H_TOTAL, 884: clocks per line; hcount range is 0..H_TOTAL-1
- V_ACTIVE, 350: active lines
- V_SYNC_START, 349: vcount at which VSYNC goes active (low)
- V_SYNC_END, 365: vcount at which VSYNC returns high
- V_TOTAL, 369: lines per frame
- CELL_W, 9: pixels per character cell (8 font bits + 1 extra column)
- CELL_H, 14: scanlines per cell; UL_LINE, 12: underline scanline
- COLS, 80; ROWS, 25: text grid; text address = row*COLS + col
- BLINK_FRAMES, 16: frames per character-blink half period; cursor blinks at BLINK_FRAMES/2

Ports:
- clock  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- text_addr  out  $clog2(COLS*ROWS)  text RAM read address
- text_data  in  16  {attr[7:0], char[7:0]}, valid one clock after text_addr
- font_addr  out  12  {char[7:0], scanline[3:0]}
- font_data  in  8  glyph row, bit 7 = leftmost pixel, valid one clock after font_addr
- cursor_en  in  1  cursor enable
- cursor_row  in  $clog2(ROWS); cursor_col  in  $clog2(COLS)
- cursor_start, cursor_end  in  4 each  first/last cursor scanline (inclusive)
- MDA_HSYNC  out  1  active high
- MDA_VSYNC  out  1  active low
- MDA_DATA  out  1  video
- MDA_INTENSITY  out  1  bright
- frame_start  out  1  one-clock pulse when raw hcount=0, vcount=0

## Operation

- Stage 0 counters: hcount 0..H_TOTAL-1; vcount advances when hcount wraps, 0..V_TOTAL-1. Within active region, pixel-in-cell px (0..CELL_W-1), col, scanline sl (0..CELL_H-1), row kept as incrementing counters (no divide); all reset to 0 at line/frame wrap.
- Stage 1: text_addr registered from (row, col); sideband (px, sl, active, hsync, vsync, cursor-hit) carried in a delay pipeline.
- Stage 2: text_data arrives; font_addr <= {char, sl}; attr registered forward.
- Stage 3: font_data arrives; pixel bit = font_data[7-px] for px<8; px==8: font_data[0] if char in 0xC0..0xDF, else 0.
- Stage 4 attribute decode, registered to outputs (fg=attr[2:0], bg=attr[6:4]):
  - attr & 0x77 == 0: non-display, DATA=0.
  - fg==0, bg==7: reverse, DATA = ~pixel.
  - else DATA = pixel; fg==1 and sl==UL_LINE forces DATA=1.
  - attr[7]=1 and blink phase off: foreground suppressed (reverse cells show solid background).
  - INTENSITY = attr[3] & DATA.
  - Cursor: cursor_en, row/col match, cursor_start<=sl<=cursor_end and cursor phase on → DATA=1, INTENSITY=1; overrides all above.
  - Outside active region DATA=INTENSITY=0.
- Blink: frame counter increments on frame_start; char phase toggles every BLINK_FRAMES frames, cursor phase every BLINK_FRAMES/2. Both phases start "on".
- Cursor inputs sampled at stage 0 with the pixel; changes take effect on the next pixel.

## Timing

- Fixed 4-clock latency from raw counters to outputs; HSYNC/VSYNC delayed by the same 4 clocks so video/sync alignment equals raw-counter alignment.
- HSYNC high for raw hcount in [H_SYNC_START, H_SYNC_END); VSYNC low for vcount in [V_SYNC_START, V_SYNC_END).
- frame_start is not delayed (raw timing).
- Reset (async assert, sync release): all counters, pipeline, blink counters 0; MDA_HSYNC=0, MDA_VSYNC=1, MDA_DATA=0, MDA_INTENSITY=0, frame_start=0, text_addr=0, font_addr=0. First frame_start one clock after release.
- Reset mid-frame: outputs return to reset values immediately; no partial-line continuation.
- Parameters with H_ACTIVE ≠ COLS*CELL_W or V_ACTIVE ≠ ROWS*CELL_H are illegal (elaboration assertion).

## Test plan

- Reset release, run 2 frames: MDA_HSYNC period 884 clocks, high 135 clocks; VSYNC low 16 lines per 369-line frame; frame_start every 884*369 clocks.
- Text RAM all 0x0741 ('A', attr 07), font model returns 0xFF: DATA high for px 0..7, low at px 8 of each cell; INTENSITY 0; first DATA high exactly 4 clocks after frame_start.
- Char 0xC4, font 0x01: px 8 DATA=1; same with char 0x41: px 8 DATA=0.
- attr 0x70, font 0x00: DATA=1 across cell; attr 0x01, font 0x00: DATA=1 only on scanline 12; attr 0x00: DATA=0 regardless of font.
- attr 0x8F, BLINK_FRAMES=2: foreground visible frames 0–1, suppressed frames 2–3, INTENSITY follows DATA.
- cursor_en=1, row 3 col 5, start 12 end 13: cell solid on scanlines 12–13 in frame 0, absent in frame 1 with BLINK_FRAMES=2; async reset mid-line drops all outputs to reset values same clock.
